// File: rtl/uart_tx_arbiter_if.sv
// Stream bundle between the byte producers, the arbiter and the UART bridge input.
// slave = arbiter view, master = producer/bridge (bench) view.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 3
);
  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0]            s_tvalid;
  logic [NUM_SRC-1:0]            s_tlast;
  logic [NUM_SRC-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic                          m_tvalid;
  logic                          m_tlast;
  logic                          m_tready;
  logic [NUM_SRC-1:0]            grant;
  logic [15:0]                   pkt_count;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, grant, pkt_count
  );
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, grant, pkt_count
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the UART TX stream; grant is held from
// first beat to tlast so frames never interleave, and the master side is registered.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus
);
  localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PASS = 1'b1;

  logic [0:0]            r_state;
  logic [IDXW-1:0]       r_last;
  logic [IDXW-1:0]       r_own;
  logic [NUM_SRC-1:0]    r_grant;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic [15:0]           r_pkt_count;

  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_found;
  logic [IDXW-1:0]       w_win;
  int                    w_idx;
  logic [DATA_WIDTH-1:0] w_own_data;
  logic                  w_own_last;
  logic [NUM_SRC-1:0]    w_s_tready;

  assign w_out_free = !r_m_tvalid || bus.m_tready;

  // Scan starts just past the previous owner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_idx = (int'(r_last) + k) % NUM_SRC;
      if (!w_found && bus.s_tvalid[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDXW'(w_idx);
      end
    end
  end

  always_comb begin
    w_own_data = '0;
    w_own_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant[i]) begin
        w_own_data = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_own_last = bus.s_tlast[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rdy
    assign w_s_tready[gi] = (r_state == S_PASS) && r_grant[gi] && w_out_free;
  end

  assign w_accept = |(w_s_tready & bus.s_tvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= IDXW'(NUM_SRC - 1);
      r_own       <= '0;
      r_grant     <= '0;
      r_m_tdata   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      // Load and drain may coincide, which keeps one beat per cycle.
      if (w_accept) begin
        r_m_tdata  <= w_own_data;
        r_m_tlast  <= w_own_last;
        r_m_tvalid <= 1'b1;
      end else if (bus.m_tready) begin
        r_m_tvalid <= 1'b0;
      end

      if (r_m_tvalid && bus.m_tready && r_m_tlast)
        r_pkt_count <= r_pkt_count + 16'd1;

      if (r_state == S_IDLE) begin
        if (w_found) begin
          r_grant <= NUM_SRC'(1) << w_win;
          r_own   <= w_win;
          r_state <= S_PASS;
        end
      end else begin
        if (w_accept && w_own_last) begin
          r_grant <= '0;
          r_last  <= r_own;
          r_state <= S_IDLE;
        end
      end
    end
  end

  assign bus.s_tready  = w_s_tready;
  assign bus.m_tdata   = r_m_tdata;
  assign bus.m_tvalid  = r_m_tvalid;
  assign bus.m_tlast   = r_m_tlast;
  assign bus.grant     = r_grant;
  assign bus.pkt_count = r_pkt_count;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-source beat queues drive the sources, a queue-based
// transaction model predicts grant, ready, output stream and packet count each cycle.
module tb_uart_tx_arbiter;
  localparam int DW = 8;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus();
  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [7:0] d; logic l; int gap; } beat_t;
  typedef struct { logic [7:0] d; logic l; int s; } obeat_t;

  beat_t  srcq [NS][$];
  bit     pres [NS];
  obeat_t oq[$];
  int     order[$];
  bit     busy;
  int     owner, lastg, cnt;
  int     n_chk, n_err, cyc, acc_cnt;
  int     rdy_pct;
  bit     rdy_script[$];
  int     first_sv, first_mv, g1_cyc;
  bit     saw_ffff;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic add(int s, logic [7:0] d, logic l, int gap);
    srcq[s].push_back('{d: d, l: l, gap: gap});
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      pres[i] = 1'b0;
    end
    oq.delete(); order.delete(); rdy_script.delete();
    busy = 1'b0; owner = 0; lastg = NS - 1; cnt = 0; acc_cnt = 0;
    rdy_pct = 100; first_sv = -1; first_mv = -1; g1_cyc = 0; saw_ffff = 1'b0;
    bus.s_tvalid = '0; bus.s_tlast = '0; bus.s_tdata = '0; bus.m_tready = 1'b0;
  endtask

  task automatic chk_zero(string pfx);
    chk({pfx, "_grant"},     32'(bus.grant), 0);
    chk({pfx, "_m_tvalid"},  32'(bus.m_tvalid), 0);
    chk({pfx, "_m_tdata"},   32'(bus.m_tdata), 0);
    chk({pfx, "_m_tlast"},   32'(bus.m_tlast), 0);
    chk({pfx, "_s_tready"},  32'(bus.s_tready), 0);
    chk({pfx, "_pkt_count"}, 32'(bus.pkt_count), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_zero("rst");
  endtask

  // One cycle: check registered outputs, drive inputs, check ready, advance model.
  task automatic step();
    logic [NS-1:0] exp_rdy;
    bit acc;
    beat_t b;
    chk("grant", 32'(bus.grant), busy ? 32'(1 << owner) : 32'd0);
    chk("m_tvalid", 32'(bus.m_tvalid), 32'(oq.size() != 0));
    if (oq.size() != 0) begin
      chk("m_tdata", 32'(bus.m_tdata), 32'(oq[0].d));
      chk("m_tlast", 32'(bus.m_tlast), 32'(oq[0].l));
    end
    chk("pkt_count", 32'(bus.pkt_count), 32'(cnt));
    if (bus.m_tvalid && first_mv < 0) first_mv = cyc;
    if (bus.grant == 3'b001) g1_cyc++;
    if (bus.pkt_count == 16'hFFFF) saw_ffff = 1'b1;

    for (int i = 0; i < NS; i++) begin
      if (!pres[i] && srcq[i].size() != 0) begin
        b = srcq[i][0];
        if (b.gap > 0) begin
          b.gap--;
          srcq[i][0] = b;
        end else pres[i] = 1'b1;
      end
      bus.s_tvalid[i] = pres[i];
      if (pres[i]) begin
        bus.s_tlast[i] = srcq[i][0].l;
        bus.s_tdata[i*DW +: DW] = srcq[i][0].d;
      end else begin
        bus.s_tlast[i] = 1'b0;
        bus.s_tdata[i*DW +: DW] = 8'($urandom);
      end
    end
    if (bus.s_tvalid != 0 && first_sv < 0) first_sv = cyc;
    if (rdy_script.size() != 0) bus.m_tready = rdy_script.pop_front();
    else bus.m_tready = ($urandom_range(99) < rdy_pct);
    #1;

    exp_rdy = '0;
    if (busy && (oq.size() == 0 || bus.m_tready)) exp_rdy[owner] = 1'b1;
    chk("s_tready", 32'(bus.s_tready), 32'(exp_rdy));

    acc = busy && pres[owner] && (oq.size() == 0 || bus.m_tready);
    if (oq.size() != 0 && bus.m_tready) begin
      if (oq[0].l) begin
        cnt = (cnt + 1) % 65536;
        order.push_back(oq[0].s);
      end
      void'(oq.pop_front());
    end
    if (acc) begin
      b = srcq[owner].pop_front();
      oq.push_back('{d: b.d, l: b.l, s: owner});
      pres[owner] = 1'b0;
      acc_cnt++;
      if (b.l) begin
        busy  = 1'b0;
        lastg = owner;
      end
    end else if (!busy) begin
      for (int k = 1; k <= NS; k++) begin
        int j;
        j = (lastg + k) % NS;
        if (!busy && pres[j]) begin
          busy  = 1'b1;
          owner = j;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic bit pending();
    bit p;
    p = busy || (oq.size() != 0);
    for (int i = 0; i < NS; i++) if (srcq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_done(int maxc);
    int n;
    n = 0;
    while (pending() && n < maxc) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= maxc), 0);
    step();
  endtask

  initial begin
    int len;
    int s;
    n_chk = 0; n_err = 0; cyc = 0;
    model_reset();
    do_reset();

    // single source, 4-byte packet
    add(0, 8'h11, 1'b0, 0); add(0, 8'h22, 1'b0, 0);
    add(0, 8'h33, 1'b0, 0); add(0, 8'h44, 1'b1, 0);
    run_done(50);
    chk("single_latency", 32'(first_mv - first_sv), 2);
    chk("single_grant_cycles", 32'(g1_cyc), 4);
    chk("single_pkt_count", 32'(bus.pkt_count), 1);

    // fairness: three sources, two 2-byte packets each
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NS; k++) begin
        add(k, 8'(16*k + 2*p), 1'b0, 0);
        add(k, 8'(16*k + 2*p + 1), 1'b1, 0);
      end
    run_done(100);
    chk("fair_npkts", 32'(order.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < order.size()) chk("fair_order", 32'(order[i]), 32'(i % NS));

    // backpressure during a 3-byte packet
    do_reset();
    add(0, 8'hA0, 1'b0, 0); add(0, 8'hA1, 1'b0, 0); add(0, 8'hA2, 1'b1, 0);
    rdy_script = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run_done(50);
    chk("bp_npkts", 32'(order.size()), 1);

    // owner stall: source 1 pauses mid-packet while source 2 requests
    do_reset();
    add(1, 8'hC1, 1'b0, 0); add(1, 8'hC2, 1'b0, 0); add(1, 8'hC3, 1'b1, 10);
    add(2, 8'hD1, 1'b1, 3);
    run_done(80);
    chk("stall_npkts", 32'(order.size()), 2);
    if (order.size() == 2) begin
      chk("stall_first", 32'(order[0]), 1);
      chk("stall_second", 32'(order[1]), 2);
    end

    // packet counter wrap
    do_reset();
    force dut.r_pkt_count = 16'hFFFE;
    #1;
    release dut.r_pkt_count;
    cnt = 65534;
    add(0, 8'h5A, 1'b1, 0); add(0, 8'h5B, 1'b1, 0);
    run_done(50);
    chk("wrap_saw_ffff", 32'(saw_ffff), 1);
    chk("wrap_zero", 32'(bus.pkt_count), 0);

    // reset after byte 2 of 5
    do_reset();
    for (int i = 0; i < 5; i++) add(0, 8'(8'h70 + i), 1'b0 | (i == 4), 0);
    for (int n = 0; n < 20 && acc_cnt < 2; n++) step();
    chk("mid_acc", 32'(acc_cnt), 2);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    do_reset();
    add(1, 8'hE1, 1'b1, 0);
    add(0, 8'hE0, 1'b1, 0);
    run_done(50);
    chk("midrst_npkts", 32'(order.size()), 2);
    if (order.size() != 0) chk("midrst_first", 32'(order[0]), 0);

    // randomized traffic with random backpressure and gaps
    do_reset();
    rdy_pct = 70;
    for (int p = 0; p < 300; p++) begin
      s   = int'($urandom_range(NS - 1));
      len = int'($urandom_range(5, 1));
      for (int k = 0; k < len; k++)
        add(s, 8'($urandom), 1'b0 | (k == len - 1),
            ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0);
    end
    run_done(20000);
    chk("rand_npkts", 32'(order.size()), 300);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
